// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper slice.
package truth_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} sweep_state_t;

  localparam int unsigned N_IN_DEF = 3;
  localparam int unsigned ROWS     = 2**N_IN_DEF;
  localparam int unsigned SETTLE_W = 8;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// Captured-table handshake: table word plus compare result, valid/ready.
interface truth_table_sweeper_if
  import truth_sweep_pkg::*;
  #(parameter int unsigned W = ROWS) ();
  logic [W-1:0] table_q;
  logic         table_valid;
  logic         table_ready;
  logic         match;

  modport master (output table_q, output table_valid, output match, input table_ready);
  modport slave  (input table_q, input table_valid, input match, output table_ready);
endinterface

// File: rtl/truth_table_sweeper_settle.sv
// Loadable down-counter that times how long each row is held before sampling.
module sweep_settle_timer
  import truth_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);
  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input row of a gate, samples its output after a settle interval,
// and presents the assembled truth table with a compare against EXPECTED.
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int unsigned           N_IN     = 3,
  parameter int unsigned           SETTLE   = 2,
  parameter logic [2**N_IN-1:0]    EXPECTED = 8'h80
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic [N_IN-1:0]             in_vec,
  input  logic                        dut_out,
  truth_table_sweeper_if.master       tbl
);
  localparam int unsigned          N_ROWS    = 2**N_IN;
  localparam logic [N_IN-1:0]      LAST_ROW  = N_IN'(N_ROWS - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LD = SETTLE_W'(SETTLE);

  sweep_state_t        state, state_nxt;
  logic [N_IN-1:0]     row;
  logic [N_ROWS-1:0]   table_r, table_nxt;
  logic                match_r;
  logic                load, sample, zero;

  sweep_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (state == DRIVE),
    .load_val (SETTLE_LD),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRIVE;
          load      = 1'b1;
        end
      end
      DRIVE: begin
        if (zero) begin
          sample = 1'b1;
          if (row == LAST_ROW) state_nxt = HOLD;
          else                 load      = 1'b1;
        end
      end
      HOLD: begin
        if (tbl.table_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    table_nxt      = table_r;
    table_nxt[row] = dut_out;
  end

  // match is taken from table_nxt so it is valid in the very first HOLD cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      row     <= '0;
      table_r <= '0;
      match_r <= 1'b0;
    end else if (state == IDLE && start) begin
      row     <= '0;
      table_r <= '0;
      match_r <= 1'b0;
    end else if (sample) begin
      table_r <= table_nxt;
      if (row == LAST_ROW) match_r <= (table_nxt == EXPECTED);
      else                 row     <= row + 1'b1;
    end else if (state == HOLD && tbl.table_ready) begin
      row <= '0;
    end
  end

  assign busy            = (state != IDLE);
  assign in_vec          = row;
  assign tbl.table_valid = (state == HOLD);
  assign tbl.table_q     = table_r;
  assign tbl.match       = match_r;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (SETTLE 2/0/1) driving LUT gate models.
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ready = 1'b1;
  logic [7:0] lut = 8'h00;
  int         gate_delay = 0;
  int         sel = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  logic [2:0] iv0, iv1, iv2;
  logic       b0, b1, b2;
  logic       d0, d1, d2;
  logic       pa0, pa1, pa2, pb0, pb1, pb2;

  truth_table_sweeper_if #(.W(8)) if0 ();
  truth_table_sweeper_if #(.W(8)) if1 ();
  truth_table_sweeper_if #(.W(8)) if2 ();
  assign if0.table_ready = ready;
  assign if1.table_ready = ready;
  assign if2.table_ready = ready;

  truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(8'h80)) u0 (
    .clk(clk), .rst(rst), .start(start), .busy(b0), .in_vec(iv0), .dut_out(d0), .tbl(if0.master));
  truth_table_sweeper #(.N_IN(3), .SETTLE(0), .EXPECTED(8'h80)) u1 (
    .clk(clk), .rst(rst), .start(start), .busy(b1), .in_vec(iv1), .dut_out(d1), .tbl(if1.master));
  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h80)) u2 (
    .clk(clk), .rst(rst), .start(start), .busy(b2), .in_vec(iv2), .dut_out(d2), .tbl(if2.master));

  // Gate models: LUT lookup, optionally behind a 2-stage pipeline
  always @(posedge clk) begin
    pa0 <= lut[iv0]; pb0 <= pa0;
    pa1 <= lut[iv1]; pb1 <= pa1;
    pa2 <= lut[iv2]; pb2 <= pa2;
  end
  always_comb begin
    d0 = (gate_delay == 2) ? pb0 : lut[iv0];
    d1 = (gate_delay == 2) ? pb1 : lut[iv1];
    d2 = (gate_delay == 2) ? pb2 : lut[iv2];
  end

  logic [2:0] o_iv;
  logic       o_busy, o_valid, o_match;
  logic [7:0] o_tbl;
  always_comb begin
    o_iv = iv0; o_busy = b0; o_valid = if0.table_valid; o_tbl = if0.table_q; o_match = if0.match;
    if (sel == 1) begin
      o_iv = iv1; o_busy = b1; o_valid = if1.table_valid; o_tbl = if1.table_q; o_match = if1.match;
    end else if (sel == 2) begin
      o_iv = iv2; o_busy = b2; o_valid = if2.table_valid; o_tbl = if2.table_q; o_match = if2.match;
    end
  end

  // Reference: row r occupies cycles 1+r*(S+1) .. (r+1)*(S+1), sampled on the last one
  function automatic logic [2:0] exp_in(input int t, input int s);
    int v;
    v = (t < 1) ? 0 : (t - 1) / (s + 1);
    if (v > 7) v = 7;
    return 3'(v);
  endfunction

  function automatic logic [7:0] exp_table(input logic [7:0] f, input int s, input int d);
    logic [7:0] r_tbl;
    r_tbl = '0;
    for (int r = 0; r < 8; r++) begin
      int ts;
      ts = (r + 1) * (s + 1);
      r_tbl[r] = f[exp_in(ts - d, s)];
    end
    return r_tbl;
  endfunction

  task automatic settle_idle();
    int n;
    n = 0;
    while ((b0 || b1 || b2) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (b0 || b1 || b2) begin
      errors++;
      $display("FAIL idle_timeout busy=%b%b%b want=000", b0, b1, b2);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_sweep(input int inst, input int s, input int d, input string name, input bit stall);
    logic [7:0] et;
    logic       em;
    int         vt, evt, bad_in, bad_busy, bad_hold;
    sel = inst;
    gate_delay = d;
    et  = exp_table(lut, s, d);
    em  = (et == 8'h80);
    evt = 8 * (s + 1) + 1;
    ready = !stall;
    @(posedge clk); #1;
    start = 1'b1;
    vt = -1; bad_in = 0; bad_busy = 0;
    for (int t = 1; t <= 200 && vt < 0; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (o_valid === 1'b1) vt = t;
      else begin
        if (o_iv !== exp_in(t, s)) bad_in++;
        if (o_busy !== 1'b1) bad_busy++;
      end
    end
    checks++;
    if (vt != evt) begin errors++; $display("FAIL %s valid_cycle got=%0d want=%0d", name, vt, evt); end
    checks++;
    if (bad_in != 0) begin errors++; $display("FAIL %s in_vec_steps bad_cycles=%0d want=0", name, bad_in); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL %s busy_during_sweep bad_cycles=%0d want=0", name, bad_busy); end
    checks++;
    if (o_tbl !== et) begin errors++; $display("FAIL %s table_q got=%h want=%h", name, o_tbl, et); end
    checks++;
    if (o_match !== em) begin errors++; $display("FAIL %s match got=%b want=%b", name, o_match, em); end
    checks++;
    if (o_iv !== 3'd7 || o_busy !== 1'b1) begin
      errors++; $display("FAIL %s hold_outputs in_vec=%0d busy=%b want=7 1", name, o_iv, o_busy);
    end
    if (stall) begin
      bad_hold = 0;
      for (int k = 0; k < 10; k++) begin
        start = (k % 3 == 0);
        @(posedge clk); #1;
        if (o_valid !== 1'b1 || o_tbl !== et || o_match !== em || o_iv !== 3'd7 || o_busy !== 1'b1)
          bad_hold++;
      end
      checks++;
      if (bad_hold != 0) begin errors++; $display("FAIL %s hold_stable bad_cycles=%0d want=0", name, bad_hold); end
      start = 1'b0;
      ready = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_iv !== 3'd0) begin
      errors++;
      $display("FAIL %s after_accept valid=%b busy=%b in_vec=%0d want=0 0 0", name, o_valid, o_busy, o_iv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({b0, iv0, if0.table_valid, if0.table_q, if0.match} !== 13'd0 ||
        {b1, iv1, if1.table_valid, if1.table_q, if1.match} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state u0=%b/%0d/%b/%h/%b u1=%b/%0d/%b/%h/%b want all 0",
               b0, iv0, if0.table_valid, if0.table_q, if0.match,
               b1, iv1, if1.table_valid, if1.table_q, if1.match);
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b0 !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL start_ignored_in_reset busy=%b%b want=00", b0, b2); end
  endtask

  task automatic test_and();
    lut = 8'h80;
    do_sweep(0, 2, 0, "and_s2", 1'b0);
    settle_idle();
  endtask

  task automatic test_pass_in1();
    lut = 8'hAA;
    do_sweep(0, 2, 0, "pass_in1", 1'b0);
    settle_idle();
  endtask

  task automatic test_settle0();
    lut = 8'h80;
    do_sweep(1, 0, 0, "and_s0", 1'b0);
    settle_idle();
  endtask

  task automatic test_hold_stall();
    lut = 8'hC5;
    do_sweep(0, 2, 0, "hold_stall", 1'b1);
    settle_idle();
  endtask

  task automatic test_reset_mid();
    sel = 0; gate_delay = 0; lut = 8'hFF;
    @(posedge clk); #1;
    start = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({b0, iv0, if0.table_valid, if0.table_q, if0.match} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset busy=%b in_vec=%0d valid=%b table=%h match=%b want all 0",
               b0, iv0, if0.table_valid, if0.table_q, if0.match);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lut = 8'h80;
    do_sweep(0, 2, 0, "after_reset", 1'b0);
    settle_idle();
  endtask

  task automatic test_delay();
    lut = 8'h80;
    gate_delay = 2;
    repeat (4) @(posedge clk);
    do_sweep(0, 2, 2, "delay_s2", 1'b0);
    settle_idle();
    do_sweep(2, 1, 2, "delay_s1", 1'b0);
    checks++;
    if (if2.table_q === 8'h80) begin errors++; $display("FAIL delay_s1_differs got=%h want!=80", if2.table_q); end
    settle_idle();
    gate_delay = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int inst, s, d;
      inst = int'($urandom_range(2, 0));
      s = (inst == 0) ? 2 : (inst == 1) ? 0 : 1;
      d = (s >= 2) ? 2 * int'($urandom_range(1, 0)) : 0;
      lut = (i == 0) ? 8'h80 : 8'($urandom);
      gate_delay = d;
      repeat (4) @(posedge clk);
      do_sweep(inst, s, d, "random", 1'b0);
      settle_idle();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_and();
    test_pass_in1();
    test_settle0();
    test_hold_stall();
    test_reset_mid();
    test_delay();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
